// File: rtl/xsim_msg_source_arbiter.sv
// Round-robin arbiter that hands the single message-source beat channel to one portal requester per whole message.
// Registered output one cycle after acceptance; one idle arbitration cycle between messages; downstream cannot stall.
module xsim_msg_source_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_beat,
    input  logic [32*NUM_REQ-1:0] req_portal,
    output logic                  en_beat,
    output logic [31:0]           portal,
    output logic [31:0]           beat,
    output logic                  busy,
    output logic [GW-1:0]         grant,
    output logic                  msg_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [GW-1:0] r_rr_ptr;
    logic [GW-1:0] r_grant;
    logic [15:0]   r_remaining;
    logic          r_first;
    logic [31:0]   r_portal_lat;
    logic          r_en_beat;
    logic          r_msg_done;
    logic [31:0]   r_beat;
    logic [31:0]   r_portal;

    logic          w_any;
    logic [GW-1:0] w_winner;
    logic [GW-1:0] w_idx;
    logic [31:0]   w_win_portal;
    logic [31:0]   w_cur_beat;
    logic          w_cur_vld;
    logic [NUM_REQ-1:0] w_ready;
    logic [15:0]   w_hdr_len;
    logic [15:0]   w_rem_nxt;
    logic          w_accept;
    logic          w_last;

    // Search starts at the round-robin pointer and wraps; first valid requester wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = GW'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_any && req_valid[w_idx]) begin
                w_any    = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_win_portal = '0;
        w_cur_beat   = '0;
        w_cur_vld    = 1'b0;
        w_ready      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == w_winner) begin
                w_win_portal = req_portal[32*i +: 32];
            end
            if (GW'(i) == r_grant) begin
                w_cur_beat = req_beat[32*i +: 32];
                w_cur_vld  = req_valid[i];
                w_ready[i] = (r_state == S_XFER);
            end
        end
    end

    // A zero length in the header still means the header itself is the whole message.
    assign w_hdr_len = (w_cur_beat[15:0] == 16'd0) ? 16'd1 : w_cur_beat[15:0];
    assign w_rem_nxt = r_first ? (w_hdr_len - 16'd1) : (r_remaining - 16'd1);
    assign w_accept  = (r_state == S_XFER) && w_cur_vld;
    assign w_last    = w_accept && (w_rem_nxt == 16'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)  w_state_nxt = S_XFER;
            S_XFER:  if (w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_remaining  <= '0;
            r_first      <= 1'b1;
            r_portal_lat <= '0;
            r_en_beat    <= 1'b0;
            r_msg_done   <= 1'b0;
            r_beat       <= '0;
            r_portal     <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_any) begin
                r_grant      <= w_winner;
                r_portal_lat <= w_win_portal;
                r_first      <= 1'b1;
            end
            if (w_accept) begin
                r_remaining <= w_rem_nxt;
                r_first     <= 1'b0;
                r_beat      <= w_cur_beat;
                r_portal    <= r_portal_lat;
            end
            if (w_last) begin
                r_rr_ptr <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : (r_grant + GW'(1));
            end
            r_en_beat  <= w_accept;
            r_msg_done <= w_last;
        end
    end

    assign req_ready = w_ready;
    assign en_beat   = r_en_beat;
    assign msg_done  = r_msg_done;
    assign beat      = r_beat;
    assign portal    = r_portal;
    assign busy      = (r_state == S_XFER);
    assign grant     = r_grant;

endmodule

// File: tb/tb_xsim_msg_source_arbiter.sv
// Directed bench for xsim_msg_source_arbiter: per-requester beat queues feed the DUT, a scoreboard holds the expected beat stream.
module tb_xsim_msg_source_arbiter;

    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [32*N-1:0] req_beat;
    logic [32*N-1:0] req_portal;
    logic           en_beat;
    logic [31:0]    portal;
    logic [31:0]    beat;
    logic           busy;
    logic [1:0]     grant;
    logic           msg_done;

    xsim_msg_source_arbiter #(.NUM_REQ(N), .GW(2)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_beat   (req_beat),
        .req_portal (req_portal),
        .en_beat    (en_beat),
        .portal     (portal),
        .beat       (beat),
        .busy       (busy),
        .grant      (grant),
        .msg_done   (msg_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] portal;
        logic [31:0] beat;
        logic        done;
        logic [1:0]  grant;
        logic        hdr;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rq_q[N][$];
    logic [31:0] rq_portal[N];
    int          stall_at[N];
    int          sent[N];
    int          hold[N];
    int          rise_cyc[N];
    logic [N-1:0] acc_q;
    int          cyc;
    int          hdr_cyc;
    int          done_cyc;
    bit          gap_chk;
    int          n_chk;
    int          n_pass;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add_beat(input int r, input logic [31:0] ptl, input logic [31:0] w,
                            input bit hdr, input bit done);
        exp_t e;
        rq_q[r].push_back(w);
        rq_portal[r] = ptl;
        e.portal = ptl;
        e.beat   = w;
        e.done   = done;
        e.grant  = 2'(r);
        e.hdr    = hdr;
        sb.push_back(e);
    endtask

    task automatic flush();
        sb.delete();
        for (int i = 0; i < N; i++) begin
            rq_q[i].delete();
            hold[i]     = 0;
            sent[i]     = 0;
            stall_at[i] = 0;
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        flush();
        @(posedge CLK); #1;
        RST_N = 1'b1;
    endtask

    task automatic drain(input string tag);
        int  k;
        bit  pend;
        k = 0;
        pend = 1'b1;
        while (k < 300 && pend) begin
            @(posedge CLK); #1;
            k++;
            pend = (sb.size() != 0) || busy;
            for (int i = 0; i < N; i++) if (rq_q[i].size() != 0) pend = 1'b1;
        end
        chk({tag, "_drain"}, 32'(pend), 32'd0);
    endtask

    always @(posedge CLK) acc_q <= req_valid & req_ready;

    // Monitor first (outputs of the edge just passed), then requester model update.
    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (RST_N) begin
            if (en_beat) begin
                chk("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat", beat, e.beat);
                    chk("portal", portal, e.portal);
                    chk("msg_done", 32'(msg_done), 32'(e.done));
                    chk("grant", 32'(grant), 32'(e.grant));
                    if (e.hdr) begin
                        if (gap_chk && done_cyc >= 0) chk("idle_gap", 32'(cyc - done_cyc), 32'd2);
                        hdr_cyc = cyc;
                    end
                    if (msg_done) begin
                        chk("busy_after_last", 32'(busy), 32'd0);
                        done_cyc = cyc;
                    end
                end
            end else begin
                chk("done_without_beat", 32'(msg_done), 32'd0);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (acc_q[i] && rq_q[i].size() != 0) begin
                rq_q[i].delete(0);
                sent[i]++;
                if (sent[i] == stall_at[i]) hold[i] = 3;
            end
            if (!req_valid[i] && rq_q[i].size() != 0 && hold[i] == 0) rise_cyc[i] = cyc;
            req_valid[i]         = (rq_q[i].size() != 0) && (hold[i] == 0);
            req_beat[32*i +: 32] = (rq_q[i].size() != 0) ? rq_q[i][0] : 32'h0;
            req_portal[32*i +: 32] = rq_portal[i];
            if (hold[i] > 0) hold[i]--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        n_chk = 0; n_pass = 0; n_fail = 0;
        cyc = 0; hdr_cyc = 0; done_cyc = -1; gap_chk = 1'b0;
        req_valid = '0; req_beat = '0; req_portal = '0;
        for (int i = 0; i < N; i++) begin
            rq_portal[i] = '0; stall_at[i] = 0; sent[i] = 0; hold[i] = 0; rise_cyc[i] = 0;
        end
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_en_beat", 32'(en_beat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_msg_done", 32'(msg_done), 32'd0);
        chk("rst_beat", beat, 32'd0);
        chk("rst_portal", portal, 32'd0);
        RST_N = 1'b1;

        // Single requester, 3-word message.
        @(posedge CLK); #1;
        add_beat(0, 32'd5, 32'h0003_0003, 1'b1, 1'b0);
        add_beat(0, 32'd5, 32'h0000_000A, 1'b0, 1'b0);
        add_beat(0, 32'd5, 32'h0000_000B, 1'b0, 1'b1);
        drain("t1");
        chk("t1_latency", 32'(hdr_cyc - rise_cyc[0]), 32'd2);
        chk("t1_contiguous", 32'(done_cyc - hdr_cyc), 32'd2);

        // All four at once from rr_ptr=0: order 0,1,2,3 with one idle cycle between.
        do_reset();
        gap_chk = 1'b1;
        done_cyc = -1;
        for (int r = 0; r < N; r++) begin
            add_beat(r, 32'h10 + 32'(r), (32'(r + 1) << 16) | 32'd2, 1'b1, 1'b0);
            add_beat(r, 32'h10 + 32'(r), 32'h100 + 32'(r), 1'b0, 1'b1);
        end
        drain("t2");
        gap_chk = 1'b0;
        chk("t2_grant_held", 32'(grant), 32'd3);

        // rr_ptr back at 0: req 0 beats req 3.
        add_beat(0, 32'h40, 32'h0011_0001, 1'b1, 1'b1);
        add_beat(3, 32'h43, 32'h0012_0001, 1'b1, 1'b1);
        drain("t2_ptr");

        // Zero-length header from req 2 (leaves rr_ptr=3).
        add_beat(2, 32'h22, 32'h0007_0000, 1'b1, 1'b1);
        drain("t4");
        chk("t4_same_cycle", 32'(done_cyc - hdr_cyc), 32'd0);

        // rr_ptr=3 with requesters 1 and 3: 3 first, then 1.
        add_beat(3, 32'h33, 32'h0008_0002, 1'b1, 1'b0);
        add_beat(3, 32'h33, 32'h0000_0301, 1'b0, 1'b1);
        add_beat(1, 32'h31, 32'h0009_0002, 1'b1, 1'b0);
        add_beat(1, 32'h31, 32'h0000_0101, 1'b0, 1'b1);
        drain("t3");

        // Stall mid-message on req 1 while req 0 waits.
        sent[1] = 0;
        stall_at[1] = 2;
        add_beat(1, 32'h51, 32'h0040_0004, 1'b1, 1'b0);
        add_beat(1, 32'h51, 32'h0000_0051, 1'b0, 1'b0);
        add_beat(1, 32'h51, 32'h0000_0052, 1'b0, 1'b0);
        add_beat(1, 32'h51, 32'h0000_0053, 1'b0, 1'b1);
        k = 0;
        while (k < 50 && !(busy && grant == 2'd1)) begin
            @(posedge CLK); #1; k++;
        end
        chk("t5_granted", 32'(busy && grant == 2'd1), 32'd1);
        add_beat(0, 32'h20, 32'h0041_0001, 1'b1, 1'b1);
        k = 0;
        while (k < 50 && hold[1] == 0) begin
            @(posedge CLK); #1; k++;
        end
        chk("t5_stall_seen", 32'(hold[1] != 0), 32'd1);
        chk("t5_grant_stall", 32'(grant), 32'd1);
        chk("t5_ready_stall", 32'(req_ready), 32'h2);
        chk("t5_busy_stall", 32'(busy), 32'd1);
        drain("t5");
        stall_at[1] = 0;

        // Reset during beat 2 of a 5-word message, then a fresh header from req 2.
        add_beat(2, 32'h30, 32'h0050_0005, 1'b1, 1'b0);
        add_beat(2, 32'h30, 32'h0000_00C1, 1'b0, 1'b0);
        add_beat(2, 32'h30, 32'h0000_00C2, 1'b0, 1'b0);
        add_beat(2, 32'h30, 32'h0000_00C3, 1'b0, 1'b0);
        add_beat(2, 32'h30, 32'h0000_00C4, 1'b0, 1'b1);
        k = 0;
        while (k < 50 && !(en_beat && beat == 32'h0000_00C1)) begin
            @(negedge CLK); #1; k++;
        end
        chk("t6_beat2_seen", 32'(en_beat && beat == 32'h0000_00C1), 32'd1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("t6_rst_en_beat", 32'(en_beat), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        flush();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        add_beat(2, 32'h31, 32'h0006_0002, 1'b1, 1'b0);
        add_beat(2, 32'h31, 32'h0000_0077, 1'b0, 1'b1);
        drain("t6");
        chk("t6_single_msg", 32'(done_cyc - hdr_cyc), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
